writeback_arbiter: RTL
======================

# writeback_arbiter

Drives the single write port (`wen`/`waddr`/`wdata`) of the CPU register file from two producers. The first is the in-order pipeline writeback, which always wins and is never stalled. The second is a long-latency result stream (divider / load unit) behind a valid/ready handshake and a small FIFO. The block also keeps a pending-write scoreboard that the issue stage queries to stall on operands whose long-latency result has not yet been written back.

## Interface
Parameters:
- `FIFO_DEPTH`, 2 — long-latency result buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `pipe_wen`  in  1  — pipeline writeback valid; no backpressure.
- `pipe_waddr`  in  5  — pipeline destination register.
- `pipe_wdata`  in  32  — pipeline result.
- `issue_valid`  in  1  — a long-latency op is issued this cycle.
- `issue_waddr`  in  5  — its destination register.
- `lu_valid`  in  1  — long-latency result valid.
- `lu_ready`  out  1  — result accepted when `lu_valid && lu_ready`.
- `lu_waddr`  in  5  — result destination.
- `lu_wdata`  in  32  — result data.
- `query_addr_a`, `query_addr_b`  in  5  — issue-stage source operands.
- `busy_a`, `busy_b`  out  1  — operand has an outstanding long-latency write.
- `wen`  out  1  — register file write enable (registered).
- `waddr`  out  5  — register file write address (registered).
- `wdata`  out  32  — register file write data (registered).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  — entries currently buffered.

## Operation
- Register 0 is never written:
  - A pipeline write to address 0 is ignored.
  - A long-latency result to address 0 is accepted (handshake completes) but not pushed.
  - An issue to address 0 sets no scoreboard bit.
- Per-cycle arbitration for the next `wen`/`waddr`/`wdata`:
  - **Pipeline:** `pipe_wen && pipe_waddr != 0` → drive the pipeline write. The FIFO is not popped.
  - **FIFO:** otherwise, if the FIFO is non-empty → pop the head and drive it.
  - **Idle:** otherwise `wen` = 0. `waddr`/`wdata` hold their previous values.
- `lu_ready` = `rst` deasserted and `fifo_count < FIFO_DEPTH`. It is combinational from registered count, with no dependence on `lu_valid` or `pipe_wen`.
- The FIFO is strictly in-order. Push and pop in the same cycle are legal; the count is unchanged.
- Scoreboard, `sb[31:0]`:
  - **Set:** `issue_valid` sets `sb[issue_waddr]`.
  - **Clear:** `sb[a]` clears on the cycle the FIFO entry for `a` is popped to the write port.
  - **Simultaneous:** same register set and clear in one cycle → set wins.
  - **Bit 0:** `sb[0]` is constantly 0.
- `busy_a = sb[query_addr_a]`, `busy_b = sb[query_addr_b]`. Combinational from registered state; not bypassed by same-cycle issue or pop.
- Pipeline writes never touch the scoreboard. WAW ordering between the two producers is the issue stage's responsibility, using `busy_*`.
- Reissue to a register that is already busy leaves the bit set. The first pop to that register clears it; this case is a protocol violation, flagged by an assertion.

## Timing
- Reset (async assert, sync release): `wen`=0, `waddr`=0, `wdata`=0, `sb`=0, FIFO empty, `fifo_count`=0, `lu_ready`=0 while `rst` is low.
- Pipeline write at cycle N → `wen` high during cycle N+1.
- Long-latency write accepted at cycle N → earliest `wen` during cycle N+2. It is delayed one cycle for each consecutive cycle with a pipeline write.
- Scoreboard bit set at edge after issue → `busy` visible cycle N+1. Cleared at the edge where `wen` for that entry rises → `busy` low in the same cycle `wen` is high.
- Full FIFO with continuous pipeline writes: `lu_ready` stays 0 indefinitely. There is no starvation guard.
- Reset mid-operation: buffered results and pending bits are discarded. `wen` drops asynchronously.

## Structure
- Shared package `cpu_pkg` holds:
  - `reg_addr_t` (logic [4:0]).
  - `word_t` (logic [31:0]).
  - `wb_entry_t` struct {`reg_addr_t addr; word_t data;`}.
  - Constant `REG_ZERO` = 5'd0.
- Sub-module `wb_fifo` is a parameterized synchronous FIFO of `wb_entry_t`, with push/pop/full/empty/count. It uses the same clock and async active-low reset.
- The arbiter mux, scoreboard and output registers live in `writeback_arbiter`.

## Test plan
- **Reset:** assert `rst`=0 mid-traffic (FIFO holding 2 entries, `sb`=0x0000_0030) → outputs 0, `lu_ready`=0, `busy_*`=0 immediately. After release: `lu_ready`=1, `fifo_count`=0.
- **Pipeline only:** `pipe_wen`=1, addr 5, data 0xDEADBEEF at cycle 0 → `wen`=1, `waddr`=5, `wdata`=0xDEADBEEF at cycle 1. A write to addr 0 → `wen`=0.
- **Long-latency path:**
  - Stimulus: issue addr 7 at cycle 0; result (7, 0x1234) accepted at cycle 3.
  - Response: `busy` for 7 high during cycles 1–4; `wen`=1, `waddr`=7 at cycle 5; `busy` low at cycle 5.
- **Priority/backpressure:**
  - Stimulus: `pipe_wen` every cycle for 6 cycles while offering 3 results.
  - Response: 2 accepted, `lu_ready`=0 after; buffered results written in order on the 2 cycles after the pipeline stops.
- **Simultaneous events:** same cycle issue addr 9 and pop of an entry for addr 9 → `busy` stays 1. Push+pop with `fifo_count`=1 → count remains 1.
- **Register 0:** result to addr 0 → handshake completes, `fifo_count` unchanged, no `wen`. Issue to addr 0 → `busy` for 0 stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types for the register file writeback path.
//   reg_addr_t  : architectural register index (x0..x31)
//   word_t      : 32-bit data word
//   wb_entry_t  : one buffered writeback (destination + data)
//   REG_ZERO    : hard-wired zero register, never written
package cpu_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    reg_addr_t addr;
    word_t     data;
  } wb_entry_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // True for every register that may actually be written.
  function automatic logic is_writable(input reg_addr_t addr);
    return (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer of long-latency writeback entries.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   push_i, push_data_i    : enqueue one entry (ignored when full)
//   pop_i                  : dequeue the head (ignored when empty)
//   pop_data_o             : current head entry
//   full_o, empty_o        : occupancy flags
//   count_o                : number of buffered entries
module wb_fifo
  import cpu_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  wb_entry_t     push_data_i,
  input  logic          pop_i,
  output wb_entry_t     pop_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s, pop_s;

  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == CNT_ZERO);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign push_s = push_i && !full_o;
  assign pop_s  = pop_i && !empty_o;

  // Pointer and occupancy next state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful behind the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/writeback_arbiter_chk.sv
// Protocol checks for writeback_arbiter.
// Ports: clk/rst, issue request, scoreboard state and this cycle's clear mask.
module writeback_arbiter_chk
  import cpu_pkg::*;
(
  input logic        clk,
  input logic        rst,
  input logic        issue_valid,
  input logic [4:0]  issue_waddr,
  input logic [31:0] sb_q,
  input logic [31:0] sb_clr
);

  // Issuing to a register whose long-latency write is still outstanding (and
  // not leaving this cycle) would let the older pop clear the newer pending bit.
  a_no_reissue_busy: assert property (@(posedge clk) disable iff (!rst)
    !(issue_valid && (issue_waddr != REG_ZERO) && sb_q[issue_waddr] && !sb_clr[issue_waddr]));

  // The zero register never shows as pending.
  a_sb_zero: assert property (@(posedge clk) disable iff (!rst) (sb_q[0] == 1'b0));

endmodule

// File: rtl/writeback_arbiter.sv
// Single write-port arbiter for the register file.
// The pipeline writeback always wins; long-latency results are buffered in an
// in-order FIFO and drained on cycles the pipeline leaves free. A pending-write
// scoreboard tells the issue stage which registers still await a result.
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   pipe_wen/waddr/wdata          : pipeline writeback (no backpressure)
//   issue_valid/issue_waddr       : long-latency op issued (sets pending bit)
//   lu_valid/lu_ready/waddr/wdata : long-latency result handshake
//   query_addr_a/b, busy_a/b      : scoreboard lookups for issue operands
//   wen/waddr/wdata               : registered register file write port
//   fifo_count                    : buffered result count
module writeback_arbiter
  import cpu_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 2,
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_wen,
  input  logic [4:0]    pipe_waddr,
  input  logic [31:0]   pipe_wdata,
  input  logic          issue_valid,
  input  logic [4:0]    issue_waddr,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [4:0]    lu_waddr,
  input  logic [31:0]   lu_wdata,
  input  logic [4:0]    query_addr_a,
  input  logic [4:0]    query_addr_b,
  output logic          busy_a,
  output logic          busy_b,
  output logic          wen,
  output logic [4:0]    waddr,
  output logic [31:0]   wdata,
  output logic [CW-1:0] fifo_count
);

  logic          pipe_sel_s;
  logic          push_s, pop_s;
  logic          fifo_full_s, fifo_empty_s;
  wb_entry_t     push_entry_s, head_s;
  logic [31:0]   sb_q, sb_d, sb_set_s, sb_clr_s;
  logic          wen_q, wen_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  assign pipe_sel_s = pipe_wen && is_writable(pipe_waddr);
  // Ready depends only on reset and registered occupancy, never on lu_valid.
  assign lu_ready   = rst && !fifo_full_s;
  // Results for x0 complete the handshake but are dropped here.
  assign push_s     = lu_valid && lu_ready && is_writable(lu_waddr);
  assign pop_s      = !pipe_sel_s && !fifo_empty_s;

  assign push_entry_s.addr = lu_waddr;
  assign push_entry_s.data = lu_wdata;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .pop_data_o  (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count)
  );

  // Write-port source select; address/data hold when idle.
  always_comb begin
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    sb_clr_s = 32'd0;
    if (pipe_sel_s) begin
      wen_d   = 1'b1;
      waddr_d = pipe_waddr;
      wdata_d = pipe_wdata;
    end else if (pop_s) begin
      wen_d   = 1'b1;
      waddr_d = head_s.addr;
      wdata_d = head_s.data;
      // Pending bit drops at the same edge the write appears on the port.
      sb_clr_s[head_s.addr] = 1'b1;
    end else begin
      wen_d = 1'b0;
    end
  end

  // Scoreboard next state: a same-cycle issue overrides the clear.
  always_comb begin
    sb_set_s = 32'd0;
    if (issue_valid && is_writable(issue_waddr)) begin
      sb_set_s[issue_waddr] = 1'b1;
    end else begin
      sb_set_s = 32'd0;
    end
    sb_d    = (sb_q & ~sb_clr_s) | sb_set_s;
    sb_d[0] = 1'b0;
  end

  // Output port and scoreboard registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      sb_q    <= 32'd0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      sb_q    <= sb_d;
    end
  end

  assign wen    = wen_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;
  assign busy_a = sb_q[query_addr_a];
  assign busy_b = sb_q[query_addr_b];

  writeback_arbiter_chk u_chk (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .sb_q        (sb_q),
    .sb_clr      (sb_clr_s)
  );

endmodule
